demux_stream_sched: RTL and testbench

//   Sequencing controller for the 1-to-N demultiplexer datapath. Accepts a valid/ready

---
 rtl/demux_stream_sched.sv | 158 +++++++++++++++
 tb/tb_demux_stream_sched.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/demux_stream_sched.sv
// demux_stream_sched: valid/ready sequencer for a 1-to-NUM_OUT demultiplexer.
//   Each accepted input beat is held in a one-entry output register and presented
//   on exactly one output channel. The channel comes from a round-robin pointer
//   (mode=0) or from the beat's in_sel (mode=1). A drain and a new accept can
//   happen in the same cycle, so the block sustains one beat per cycle.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   mode                 0 = round-robin, 1 = explicit select (sampled per beat)
//   in_valid/in_ready    input handshake; in_data payload, in_sel destination
//   out_valid[NUM_OUT]   one-hot (or zero) valid; out_ready[NUM_OUT] consumer ready
//   out_data             held payload, shared by all outputs
//   bad_sel              1-cycle pulse: beat dropped because in_sel >= NUM_OUT
//   rr_ptr               next round-robin destination
//   timeout              1-cycle pulse: stalled beat discarded (STALL_TIMEOUT_EN only)
//
// Optional feature macro: STALL_TIMEOUT_EN (stall counter + timeout port).

// One output lane: decodes the held destination and reports a drain on this lane.
module demux_stream_sched_lane #(
  parameter int SEL_W = 1,
  parameter int IDX   = 0
) (
  input  logic             hold,
  input  logic [SEL_W-1:0] dest,
  input  logic             ready,
  output logic             valid,
  output logic             drain
);
  assign valid = hold && (dest == SEL_W'(IDX));
  assign drain = valid && ready;
endmodule

module demux_stream_sched #(
  parameter int NUM_OUT = 2,
  parameter int SEL_W   = 1,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic [SEL_W-1:0]   in_sel,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               bad_sel,
  output logic [SEL_W-1:0]   rr_ptr
`ifdef STALL_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  typedef enum logic {EMPTY, HOLD} state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    dest, dest_nxt, acc_dest, rr_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [NUM_OUT-1:0]  lane_drain;
  logic                drain, accept, dest_ok, bad_nxt;
`ifdef STALL_TIMEOUT_EN
  logic [7:0]          stall_cnt, stall_nxt;
  logic                to_nxt;
`endif

  for (genvar i = 0; i < NUM_OUT; i++) begin : g_lane
    demux_stream_sched_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .hold  (state == HOLD),
      .dest  (dest),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .drain (lane_drain[i])
    );
  end

  // Only the destination lane can drain, so OR-reducing the lanes ignores
  // out_ready on every other output.
  assign drain    = |lane_drain;
  // Bypass: a draining beat frees the register for a same-cycle accept.
  // in_ready never depends on in_valid.
  assign in_ready = (state == EMPTY) || drain;
  assign accept   = in_valid && in_ready;
  assign acc_dest = mode ? in_sel : rr_ptr;
  assign dest_ok  = {{(32-SEL_W){1'b0}}, acc_dest} < 32'(NUM_OUT);

  always_comb begin
    state_nxt = state;
    dest_nxt  = dest;
    data_nxt  = out_data;
    rr_nxt    = rr_ptr;
    bad_nxt   = 1'b0;
`ifdef STALL_TIMEOUT_EN
    stall_nxt = '0;
    to_nxt    = 1'b0;
`endif
    if (accept && !mode)
      rr_nxt = (rr_ptr == SEL_W'(NUM_OUT-1)) ? '0 : rr_ptr + 1'b1;
    // An out-of-range beat is swallowed. It leaves the held beat alone, apart
    // from a drain that happens in the same cycle.
    if (accept && !dest_ok)
      bad_nxt = 1'b1;
    case (state)
      EMPTY: begin
        if (accept && dest_ok) begin
          state_nxt = HOLD;
          dest_nxt  = acc_dest;
          data_nxt  = in_data;
        end
      end
      HOLD: begin
        if (accept && dest_ok) begin
          dest_nxt  = acc_dest;
          data_nxt  = in_data;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
`ifdef STALL_TIMEOUT_EN
        else if (stall_cnt == 8'(TIMEOUT-1)) begin
          state_nxt = EMPTY;
          to_nxt    = 1'b1;
        end else begin
          stall_nxt = stall_cnt + 8'd1;
        end
`endif
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      dest      <= '0;
      out_data  <= '0;
      rr_ptr    <= '0;
      bad_sel   <= 1'b0;
`ifdef STALL_TIMEOUT_EN
      stall_cnt <= '0;
      timeout   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      dest      <= dest_nxt;
      out_data  <= data_nxt;
      rr_ptr    <= rr_nxt;
      bad_sel   <= bad_nxt;
`ifdef STALL_TIMEOUT_EN
      stall_cnt <= stall_nxt;
      timeout   <= to_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_demux_stream_sched.sv
// Directed bench for demux_stream_sched (3 outputs, so the round-robin wraps and
// in_sel=3 is out of range). Beats are pushed to a scoreboard when driven. A
// monitor pops and compares them whenever an output drains.
module tb_demux_stream_sched;
  localparam int NO = 3, SW = 2, DW = 8, TO = 16;

  logic          clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic          in_ready, bad_sel;
  logic [DW-1:0] in_data = '0, out_data;
  logic [SW-1:0] in_sel = '0, rr_ptr;
  logic [NO-1:0] out_valid, out_ready = '0;
`ifdef STALL_TIMEOUT_EN
  logic          timeout;
`endif

  typedef struct packed {
    logic [SW-1:0] dest;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0, exp_rr = 0;

  always #5 clk = ~clk;

  demux_stream_sched #(.NUM_OUT(NO), .SEL_W(SW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .bad_sel(bad_sel), .rr_ptr(rr_ptr)
`ifdef STALL_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NO-1:0] oh(input int d);
    logic [NO-1:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  // Drive one beat and record where it should land (it is accepted at the next edge).
  task automatic drive(input logic m, input logic [SW-1:0] s, input logic [DW-1:0] d);
    exp_t e;
    in_valid = 1'b1; mode = m; in_sel = s; in_data = d;
    if (!m) begin
      e.dest = SW'(exp_rr); e.data = d; sb.push_back(e);
      exp_rr = (exp_rr + 1) % NO;
    end else if (int'(s) < NO) begin
      e.dest = s; e.data = d; sb.push_back(e);
    end
  endtask

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  // Scoreboard monitor: every drain must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (rst_n) begin
      check("onehot", 32'($countones(out_valid) <= 1), 1);
      for (int i = 0; i < NO; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_dest", i, 32'(e.dest));
            check("sb_data", 32'(out_data), 32'(e.data));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    smp;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_rr", 32'(rr_ptr), 0);
    check("rst_bad", 32'(bad_sel), 0);
    check("rst_in_ready", 32'(in_ready), 1);
`ifdef STALL_TIMEOUT_EN
    check("rst_timeout", 32'(timeout), 0);
`endif
    nxt;
    rst_n = 1'b1;

    // Round-robin, all ready, four back-to-back beats
    out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, DW'(8'hA0 + i));
      smp;
      check("t1_in_ready", 32'(in_ready), 1);
      if (i > 0) begin
        check("t1_valid", 32'(out_valid), 32'(oh((i-1) % NO)));
        check("t1_data", 32'(out_data), 32'(8'hA0 + i - 1));
      end
      nxt;
    end
    in_valid = 1'b0;
    smp;
    check("t1_valid_last", 32'(out_valid), 32'(oh(3 % NO)));
    check("t1_data_last", 32'(out_data), 32'h0A3);
    nxt; smp;
    check("t1_idle", 32'(out_valid), 0);
    check("t1_rr", 32'(rr_ptr), 32'(exp_rr));
    nxt;

    // Explicit select, stall for 3 cycles (non-dest ready bits set), then drain
    out_ready = 3'b101;
    drive(1'b1, 2'd1, 8'h5A);
    nxt;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp;
      check("t2_valid", 32'(out_valid), 32'b010);
      check("t2_data", 32'(out_data), 32'h5A);
      check("t2_in_ready", 32'(in_ready), 0);
      nxt;
    end
    out_ready = 3'b010;
    smp;
    check("t2_valid_drain", 32'(out_valid), 32'b010);
    check("t2_in_ready_drain", 32'(in_ready), 1);
    nxt; smp;
    check("t2_empty", 32'(out_valid), 0);
    check("t2_rr", 32'(rr_ptr), 32'(exp_rr));
    nxt;

    // Out-of-range select
    out_ready = '1;
    drive(1'b1, 2'd3, 8'hEE);
    nxt;
    in_valid = 1'b0;
    smp;
    check("t3_bad", 32'(bad_sel), 1);
    check("t3_valid", 32'(out_valid), 0);
    check("t3_rr", 32'(rr_ptr), 32'(exp_rr));
    nxt; smp;
    check("t3_bad_clr", 32'(bad_sel), 0);
    nxt;

    // Mode switching keeps the round-robin pointer
    drive(1'b0, '0, 8'h11); nxt;
    drive(1'b1, 2'd0, 8'h22); nxt;
    check("t4_rr_hold", 32'(rr_ptr), 32'(exp_rr));
    drive(1'b0, '0, 8'h33); nxt;
    drive(1'b0, '0, 8'h44); nxt;
    in_valid = 1'b0;
    smp;
    check("t4_valid", 32'(out_valid), 32'(oh(0)));
    check("t4_data", 32'(out_data), 32'h44);
    check("t4_rr", 32'(rr_ptr), 32'(exp_rr));
    nxt;

    // Reset while holding a beat on ch1 (rr_ptr is nonzero here)
    out_ready = '0;
    drive(1'b1, 2'd1, 8'h77);
    nxt;
    in_valid = 1'b0;
    smp;
    check("t5_hold", 32'(out_valid), 32'b010);
    nxt;
    void'(sb.pop_back());
    exp_rr = 0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(out_valid), 0);
    check("t5_rst_rr", 32'(rr_ptr), 0);
    check("t5_rst_data", 32'(out_data), 0);
    nxt;
    rst_n = 1'b1;
    out_ready = '1;
    drive(1'b0, '0, 8'h88);
    nxt;
    in_valid = 1'b0;
    smp;
    check("t5_after_valid", 32'(out_valid), 32'(oh(0)));
    check("t5_after_data", 32'(out_data), 32'h88);
    nxt;

`ifdef STALL_TIMEOUT_EN
    // Stall timeout discards the held beat
    out_ready = '0;
    drive(1'b1, 2'd2, 8'h99);
    nxt;
    in_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      smp;
      check("t6_held", 32'(out_valid), 32'b100);
      check("t6_no_to", 32'(timeout), 0);
      nxt;
    end
    smp;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_timeout", 32'(timeout), 1);
    check("t6_in_ready", 32'(in_ready), 1);
    check("t6_rr", 32'(rr_ptr), 32'(exp_rr));
    void'(sb.pop_back());
    nxt; smp;
    check("t6_to_clr", 32'(timeout), 0);
`endif

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
